// File: rtl/kernel_bc_start_fifo_ext_shiftReg.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bc_start_fifo_ext_shiftReg
// Brief    : Shift-register storage for the start FIFO; entry 0 is the newest
//            word and q returns the entry selected by a.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_bc_start_fifo_ext_shiftReg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (ce) begin
            r_mem[0] <= data;
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_shift
        always_ff @(posedge clk) begin
            if (ce) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign q = r_mem[a];

endmodule
`default_nettype wire

// File: rtl/kernel_bc_start_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bc_start_fifo_ext
// Brief    : Shift-register FIFO with occupancy count, registered full/empty
//            and almost-full/almost-empty flags, and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_bc_start_fifo_ext #(
    parameter     MEM_STYLE     = "shiftreg",
    parameter int DATA_WIDTH    = 1,
    parameter int ADDR_WIDTH    = 2,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    input  logic                  if_flush,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    output logic                  if_almost_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);

    localparam int c_CW = ADDR_WIDTH + 1;

    localparam logic [c_CW-1:0]       c_ZERO    = '0;
    localparam logic [c_CW-1:0]       c_ONE     = c_CW'(1);
    localparam logic [c_CW-1:0]       c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]       c_AFULL   = c_CW'(AFULL_THRESH);
    localparam logic [c_CW-1:0]       c_AEMPTY  = c_CW'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] c_A_ONE   = ADDR_WIDTH'(1);

    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       w_cnt_next;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  r_almost_full_n;
    logic                  r_almost_empty_n;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_q;

    assign w_wr = if_write & if_write_ce & r_full_n;
    assign w_rd = if_read  & if_read_ce  & r_empty_n;

    // Oldest word sits at index cnt-1; when cnt == DEPTH == 2**ADDR_WIDTH the
    // low bits wrap to zero and the subtraction still lands on DEPTH-1.
    assign w_addr = (r_cnt == c_ZERO) ? '0 : (r_cnt[ADDR_WIDTH-1:0] - c_A_ONE);

    always_comb begin
        w_cnt_next = r_cnt;
        if (if_flush) begin
            w_cnt_next = c_ZERO;
        end else if (w_wr && !w_rd) begin
            w_cnt_next = r_cnt + c_ONE;
        end else if (w_rd && !w_wr) begin
            w_cnt_next = r_cnt - c_ONE;
        end
    end

    // Flags are registered from the next-state count so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt            <= c_ZERO;
            r_empty_n        <= 1'b0;
            r_full_n         <= 1'b1;
            r_almost_full_n  <= 1'b1;
            r_almost_empty_n <= 1'b0;
        end else begin
            r_cnt            <= w_cnt_next;
            r_empty_n        <= (w_cnt_next != c_ZERO);
            r_full_n         <= (w_cnt_next != c_DEPTH);
            r_almost_full_n  <= (w_cnt_next <  c_AFULL);
            r_almost_empty_n <= (w_cnt_next >  c_AEMPTY);
        end
    end

    if (MEM_STYLE == "shiftreg") begin : g_shiftreg
        kernel_bc_start_fifo_ext_shiftReg #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_storage (
            .clk  (clk),
            .data (if_din),
            .ce   (w_wr),
            .a    (w_addr),
            .q    (w_q)
        );
    end else begin : g_unsupported
        assign w_q = '0;
    end

    assign if_dout           = w_q;
    assign if_empty_n        = r_empty_n;
    assign if_full_n         = r_full_n;
    assign if_almost_full_n  = r_almost_full_n;
    assign if_almost_empty_n = r_almost_empty_n;
    assign if_num_data_valid = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_kernel_bc_start_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_bc_start_fifo_ext
// Brief    : Scoreboard bench for the start FIFO (DATA_WIDTH=4, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_bc_start_fifo_ext;

    localparam int c_DW     = 4;
    localparam int c_AW     = 2;
    localparam int c_DEPTH  = 4;
    localparam int c_AFULL  = 3;
    localparam int c_AEMPTY = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [c_DW-1:0] if_din;
    logic            if_write;
    logic            if_write_ce;
    logic            if_read;
    logic            if_read_ce;
    logic            if_flush;
    logic [c_DW-1:0] if_dout;
    logic            if_empty_n;
    logic            if_full_n;
    logic            if_almost_full_n;
    logic            if_almost_empty_n;
    logic [c_AW:0]   if_num_data_valid;

    int n_assert = 0;
    int n_fail   = 0;

    logic [c_DW-1:0] sb[$];

    always #5 clk = ~clk;

    kernel_bc_start_fifo_ext #(
        .MEM_STYLE     ("shiftreg"),
        .DATA_WIDTH    (c_DW),
        .ADDR_WIDTH    (c_AW),
        .DEPTH         (c_DEPTH),
        .AFULL_THRESH  (c_AFULL),
        .AEMPTY_THRESH (c_AEMPTY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_din            (if_din),
        .if_write          (if_write),
        .if_write_ce       (if_write_ce),
        .if_read           (if_read),
        .if_read_ce        (if_read_ce),
        .if_flush          (if_flush),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_full_n         (if_full_n),
        .if_almost_full_n  (if_almost_full_n),
        .if_almost_empty_n (if_almost_empty_n),
        .if_num_data_valid (if_num_data_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every status output against the scoreboard occupancy.
    task automatic chk_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"},    32'(if_num_data_valid), 32'(n));
        chk({tag, ".empty_n"},  32'(if_empty_n),        32'(n != 0));
        chk({tag, ".full_n"},   32'(if_full_n),         32'(n != c_DEPTH));
        chk({tag, ".afull_n"},  32'(if_almost_full_n),  32'(n < c_AFULL));
        chk({tag, ".aempty_n"}, 32'(if_almost_empty_n), 32'(n > c_AEMPTY));
        if (n != 0) begin
            chk({tag, ".head"}, 32'(if_dout), 32'(sb[0]));
        end
    endtask

    // One clock of stimulus; the scoreboard decides what the FIFO accepts.
    task automatic step(input string tag, input logic w, input logic wce,
                        input logic [c_DW-1:0] d, input logic r, input logic rce,
                        input logic fl);
        logic acc_w;
        logic acc_r;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        if_flush    = fl;
        acc_w = w && wce && (sb.size() < c_DEPTH);
        acc_r = r && rce && (sb.size() > 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (acc_r) begin
                chk({tag, ".rd"}, 32'(if_dout), 32'(sb.pop_front()));
            end
            if (acc_w) begin
                sb.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_flush = 1'b0;
        chk_state(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic [c_DW-1:0] d);
        reset    = 1'b1;
        if_write = w;
        if_din   = d;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        if_write = 1'b0;
        sb.delete();
        chk_state(tag);
    endtask

    initial begin
        reset       = 1'b1;
        if_din      = '0;
        if_write    = 1'b0;
        if_write_ce = 1'b1;
        if_read     = 1'b0;
        if_read_ce  = 1'b1;
        if_flush    = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset", 1'b0, 4'h0);

        // Fill to full, try one more, then drain in order.
        step("wrA", 1, 1, 4'hA, 0, 1, 0);
        step("wrB", 1, 1, 4'hB, 0, 1, 0);
        step("wrC", 1, 1, 4'hC, 0, 1, 0);
        step("wrD", 1, 1, 4'hD, 0, 1, 0);
        step("wr_full", 1, 1, 4'hF, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 4'h0, 1, 1, 0);
        step("rd_empty", 0, 1, 4'h0, 1, 1, 0);

        // Full with simultaneous read and write.
        step("wrA2", 1, 1, 4'hA, 0, 1, 0);
        step("wrB2", 1, 1, 4'hB, 0, 1, 0);
        step("wrC2", 1, 1, 4'hC, 0, 1, 0);
        step("wrD2", 1, 1, 4'hD, 0, 1, 0);
        step("full_rw", 1, 1, 4'hE, 1, 1, 0);

        // Count 2 with simultaneous read and write.
        step("rdB", 0, 1, 4'h0, 1, 1, 0);
        step("cnt2_rw", 1, 1, 4'h7, 1, 1, 0);
        step("rdD", 0, 1, 4'h0, 1, 1, 0);
        step("rd7", 0, 1, 4'h0, 1, 1, 0);

        // Empty with simultaneous read and write.
        step("empty_rw", 1, 1, 4'h5, 1, 1, 0);
        chk("empty_rw.dout", 32'(if_dout), 32'h5);

        // Flush with concurrent write at count 3.
        step("wr1", 1, 1, 4'h1, 0, 1, 0);
        step("wr2", 1, 1, 4'h2, 0, 1, 0);
        step("flush", 1, 1, 4'h9, 0, 1, 1);
        step("wce_off", 1, 0, 4'h8, 0, 1, 0);
        step("rce_off_wr", 1, 1, 4'h6, 0, 1, 0);
        step("rce_off", 0, 1, 4'h0, 1, 0, 0);

        // Reset mid-stream with a write pending.
        step("wr3", 1, 1, 4'h3, 0, 1, 0);
        do_reset("mid_reset", 1'b1, 4'hC);
        step("post_reset_wr", 1, 1, 4'h6, 0, 1, 0);
        chk("post_reset.dout", 32'(if_dout), 32'h6);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
